// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the shift_pipe_arbiter slice.
// Contents:
//   DEF_N_REQ, DEF_DEPTH, DEF_W : default parameter values
//   clog2(n)                    : ceiling log2, where clog2(1) is 0
//   id_w(n)                     : width of a requester ID, max(1, clog2(n))
package pipe_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_W     = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int id_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_pipe_arbiter_if.sv
// Bus bundle between the sample producers and shift_pipe_arbiter.
//
// Handshake: req[i] acts as "valid" for requester i. gnt[i] acts as "ready"
// and is combinational in the same cycle. A sample transfers on a rising
// edge where req[i] and gnt[i] are both 1. A requester keeps req[i] and its
// din slice stable until it sees gnt[i]. It may drop req[i] without a grant,
// and then it is not served. gnt is forced to 0 while hold or rst is high.
//
// Signals (direction as seen by the arbiter):
//   hold      in   freezes the pipeline and the pointer, and blocks grants
//   req       in   N_REQ request bits
//   din       in   N_REQ*W packed samples; requester i drives din[i*W +: W]
//   gnt       out  one-hot grant
//   dout      out  sample leaving the last stage
//   dout_vld  out  dout carries a granted sample
//   dout_id   out  owner ID of dout
//   occupancy out  number of valid stages
//   dbg_ptr   out  current round-robin pointer, exported for observation
interface shift_pipe_arbiter_if
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) ();

  localparam int ID_W  = id_w(N_REQ);
  localparam int OCC_W = clog2(DEPTH + 1);

  logic                 hold;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   din;
  logic [N_REQ-1:0]     gnt;
  logic [W-1:0]         dout;
  logic                 dout_vld;
  logic [ID_W-1:0]      dout_id;
  logic [OCC_W-1:0]     occupancy;
  logic [ID_W-1:0]      dbg_ptr;

  modport master (
    output hold, req, din,
    input  gnt, dout, dout_vld, dout_id, occupancy, dbg_ptr
  );

  modport slave (
    input  hold, req, din,
    output gnt, dout, dout_vld, dout_id, occupancy, dbg_ptr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The scan starts at ptr and wraps modulo N_REQ. The first set request wins.
// After a grant to i, ptr moves to (i+1) mod N_REQ. Without a grant, ptr
// keeps its value.
// Ports:
//   clk, rst  clock, synchronous active-high reset (ptr -> 0)
//   req       request vector
//   en        grant enable (low while the pipeline is held)
//   gnt       one-hot grant, combinational
//   gnt_idx   index of the granted requester (0 when none)
//   gnt_any   a grant is issued this cycle
//   ptr       current highest-priority requester
module rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any,
  output logic [ID_W-1:0]  ptr
);

  int              cand;
  logic [ID_W-1:0] cidx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    cidx    = '0;
    if (en && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        // ptr is always below N_REQ, so one subtraction completes the wrap.
        cand = int'(ptr) + k;
        if (cand >= N_REQ) cand = cand - N_REQ;
        cidx = ID_W'(cand);
        if (!gnt_any && req[cidx]) begin
          gnt_any   = 1'b1;
          gnt[cidx] = 1'b1;
          gnt_idx   = cidx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      // Wrap explicitly so a non-power-of-two N_REQ never sees ptr >= N_REQ.
      ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shift_pipe_arbiter.sv
// Round-robin scheduler that feeds one shared DEPTH-stage shift pipeline.
// Each non-hold cycle, at most one requester is granted. Its sample and ID
// go into stage 0, and every stage shifts forward. After DEPTH edges the
// sample appears on dout with dout_vld and dout_id.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset; flushes all in-flight samples
//   bus   shift_pipe_arbiter_if.slave (hold/req/din in;
//         gnt/dout/dout_vld/dout_id/occupancy/dbg_ptr out)
module shift_pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_pipe_arbiter_if.slave  bus
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int OCC_W = clog2(DEPTH + 1);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [ID_W-1:0]  ptr;
  logic             arb_en;

  logic [W-1:0]     st_data [DEPTH];
  logic [ID_W-1:0]  st_id   [DEPTH];
  logic [DEPTH-1:0] st_vld;
  logic [OCC_W-1:0] occ;
  logic [W-1:0]     ld_data;

  assign arb_en = !bus.hold;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any),
    .ptr     (ptr)
  );

  // Idle cycles load zeros, so an empty stage never carries stale data.
  always_comb begin
    ld_data = '0;
    if (gnt_any) ld_data = bus.din[int'(gnt_idx)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        st_data[k] <= '0;
        st_id[k]   <= '0;
      end
      st_vld <= '0;
      occ    <= '0;
    end else if (!bus.hold) begin
      st_data[0] <= ld_data;
      st_id[0]   <= gnt_any ? gnt_idx : '0;
      st_vld[0]  <= gnt_any;
      for (int k = 1; k < DEPTH; k++) begin
        st_data[k] <= st_data[k-1];
        st_id[k]   <= st_id[k-1];
        st_vld[k]  <= st_vld[k-1];
      end
      // Entry at stage 0 and exit from the last stage cancel out.
      case ({gnt_any, st_vld[DEPTH-1]})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.dout      = st_data[DEPTH-1];
  assign bus.dout_vld  = st_vld[DEPTH-1];
  assign bus.dout_id   = st_id[DEPTH-1];
  assign bus.occupancy = occ;
  assign bus.dbg_ptr   = ptr;

endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// Testbench for shift_pipe_arbiter at its default parameters (N_REQ=4, DEPTH=3, W=1).
// A reference model written from the behavioural description predicts the
// grant, pointer, stage contents and occupancy. Granted samples go into a
// scoreboard queue and are popped when they reach the last stage.
module tb_shift_pipe_arbiter;
  import pipe_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int DEPTH = 3;
  localparam int W     = 1;
  localparam int ID_W  = id_w(N_REQ);
  localparam int OCC_W = clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_pipe_arbiter_if #(.N_REQ(N_REQ), .DEPTH(DEPTH), .W(W)) bus ();

  shift_pipe_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model + scoreboard ----------------
  int               m_ptr;
  logic             m_vld  [DEPTH];
  int               m_id   [DEPTH];
  logic [W-1:0]     m_data [DEPTH];
  logic [ID_W+W-1:0] exp_q[$];
  logic [N_REQ-1:0] last_gnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] model_gnt(input logic [N_REQ-1:0] r, input logic h,
                                                 input logic rs, input int p, output int idx);
    logic [N_REQ-1:0] g;
    int c;
    g   = '0;
    idx = -1;
    if (!rs && !h) begin
      for (int k = 0; k < N_REQ; k++) begin
        c = (p + k) % N_REQ;
        if (idx < 0 && r[c]) begin
          idx  = c;
          g[c] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // ---------------- driver ----------------
  // One cycle. Drive the inputs, check gnt/ptr before the edge, advance the
  // model on the edge, then check the registered outputs.
  task automatic tick(input logic [N_REQ-1:0] r, input logic [N_REQ*W-1:0] d,
                      input logic h, input logic rs);
    logic [N_REQ-1:0]  eg;
    logic [ID_W+W-1:0] sb;
    int gi;
    int cnt;
    bit popped;
    bus.req  = r;
    bus.din  = d;
    bus.hold = h;
    rst      = rs;
    #2;
    eg = model_gnt(r, h, rs, m_ptr, gi);
    check("gnt", 32'(bus.gnt), 32'(eg));
    if (!rs) check("ptr", 32'(bus.dbg_ptr), 32'(m_ptr));
    last_gnt = bus.gnt;
    @(posedge clk);
    popped = 0;
    if (rs) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_vld[k] = 1'b0; m_id[k] = 0; m_data[k] = '0;
      end
      m_ptr = 0;
      exp_q.delete();
    end else if (!h) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_vld[k] = m_vld[k-1]; m_id[k] = m_id[k-1]; m_data[k] = m_data[k-1];
      end
      m_vld[0]  = (gi >= 0);
      m_id[0]   = (gi >= 0) ? gi : 0;
      m_data[0] = (gi >= 0) ? d[gi*W +: W] : '0;
      if (gi >= 0) begin
        exp_q.push_back({ID_W'(gi), d[gi*W +: W]});
        m_ptr = (gi + 1) % N_REQ;
      end
      popped = m_vld[DEPTH-1];
    end
    #1;
    check("dout_vld", 32'(bus.dout_vld), 32'(m_vld[DEPTH-1]));
    check("dout", 32'(bus.dout), 32'(m_data[DEPTH-1]));
    check("dout_id", 32'(bus.dout_id), 32'(m_id[DEPTH-1]));
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) cnt += int'(m_vld[k]);
    check("occupancy", 32'(bus.occupancy), 32'(cnt));
    if (popped) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(0), 32'(1));
      end else begin
        sb = exp_q.pop_front();
        check("sb_sample", 32'({bus.dout_id, bus.dout}), 32'(sb));
      end
    end
  endtask

  function automatic logic [N_REQ*W-1:0] rnd_din();
    return (N_REQ*W)'($urandom);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, rnd_din(), 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_ptr = 0;
    for (int k = 0; k < DEPTH; k++) begin
      m_vld[k] = 1'b0; m_id[k] = 0; m_data[k] = '0;
    end
    rst      = 1'b1;
    bus.req  = '0;
    bus.din  = '0;
    bus.hold = 1'b0;
    @(posedge clk);
    #1;

    // Reset held 2 cycles with all requesting: no grants.
    tick(4'b1111, rnd_din(), 1'b0, 1'b1);
    check("rst_gnt0", 32'(last_gnt), 32'(0));
    tick(4'b1111, rnd_din(), 1'b0, 1'b1);
    check("rst_vld0", 32'(bus.dout_vld), 32'(0));
    check("rst_occ0", 32'(bus.occupancy), 32'(0));
    tick(4'b1111, rnd_din(), 1'b0, 1'b0);
    check("first_gnt", 32'(last_gnt), 32'(4'b0001));
    idle(4);

    // Single requester 2 with sample 1: out after 3 edges.
    tick(4'b0100, 4'b0100, 1'b0, 1'b0);
    check("single_gnt", 32'(last_gnt), 32'(4'b0100));
    idle(2);
    check("single_vld", 32'(bus.dout_vld), 32'(1));
    check("single_id", 32'(bus.dout_id), 32'(2));
    check("single_dout", 32'(bus.dout), 32'(1));
    idle(1);
    check("single_occ_after", 32'(bus.occupancy), 32'(0));
    idle(2);

    // Round robin: all requesting for 8 cycles.
    for (int i = 0; i < 8; i++) tick(4'b1111, rnd_din(), 1'b0, 1'b0);
    check("rr_occ_sat", 32'(bus.occupancy), 32'(DEPTH));
    idle(4);

    // Hold: grant to 1, then 2 hold cycles with everyone requesting.
    tick(4'b0010, rnd_din(), 1'b0, 1'b0);
    check("hold_grant", 32'(last_gnt), 32'(4'b0010));
    tick(4'b1111, rnd_din(), 1'b1, 1'b0);
    check("hold_gnt0_a", 32'(last_gnt), 32'(0));
    tick(4'b1111, rnd_din(), 1'b1, 1'b0);
    check("hold_gnt0_b", 32'(last_gnt), 32'(0));
    check("hold_occ", 32'(bus.occupancy), 32'(1));
    idle(1);
    check("hold_not_yet", 32'(bus.dout_vld), 32'(0));
    idle(1);
    check("hold_late_vld", 32'(bus.dout_vld), 32'(1));
    check("hold_late_id", 32'(bus.dout_id), 32'(1));
    idle(3);

    // Reset mid-flight: three grants, then a 1-cycle reset flushes them.
    for (int i = 0; i < 3; i++) tick(4'b1111, rnd_din(), 1'b0, 1'b0);
    tick(4'b1111, rnd_din(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("flush_vld", 32'(bus.dout_vld), 32'(0));
    end
    check("flush_occ", 32'(bus.occupancy), 32'(0));

    // Skip idle ports: ptr = 1 with req = 1001.
    tick(4'b0001, rnd_din(), 1'b0, 1'b0);
    check("skip_ptr1", 32'(bus.dbg_ptr), 32'(1));
    tick(4'b1001, rnd_din(), 1'b0, 1'b0);
    check("skip_gnt3", 32'(last_gnt), 32'(4'b1000));
    check("skip_ptr0", 32'(bus.dbg_ptr), 32'(0));
    tick(4'b1001, rnd_din(), 1'b0, 1'b0);
    check("skip_gnt0", 32'(last_gnt), 32'(4'b0001));
    idle(4);

    // rst and hold together: reset wins.
    for (int i = 0; i < 2; i++) tick(4'b1111, rnd_din(), 1'b0, 1'b0);
    tick(4'b1111, rnd_din(), 1'b1, 1'b1);
    check("rsthold_occ", 32'(bus.occupancy), 32'(0));
    check("rsthold_ptr", 32'(bus.dbg_ptr), 32'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick(N_REQ'($urandom_range(0, (1 << N_REQ) - 1)), rnd_din(),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(DEPTH + 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_pipe_arbiter.md
# shift_pipe_arbiter

Round-robin scheduler that shares one fixed-depth shift-register delay pipeline among several requesters. Each cycle it grants at most one requester, pushes that requester's sample and ID tag into stage 0, and shifts every stage forward. After exactly DEPTH clock edges the sample leaves the pipeline with its valid flag and owner ID. The block sits between multiple sample producers and a shared delay-line datapath.

## Interface
- N_REQ, default 4: number of requesters, range 2..8.
- DEPTH, default 3: pipeline stages, i.e. latency in clock edges, range 1..16.
- W, default 1: sample width in bits.
- clk  in  1: single clock; all state changes on the rising edge.
- rst  in  1: reset, synchronous and active-high.
- hold  in  1: freezes the pipeline and the pointer, and suppresses grants.
- req  in  N_REQ: request vector, bit i belongs to requester i.
- din  in  N_REQ*W: packed samples; requester i drives din[i*W +: W].
- gnt  out  N_REQ: one-hot grant, combinational from req, ptr, hold and rst.
- dout  out  W: sample leaving the last stage.
- dout_vld  out  1: dout carries a granted sample.
- dout_id  out  ID_W: owner of dout, where ID_W = max(1, clog2(N_REQ)).
- occupancy  out  clog2(DEPTH+1): count of valid stages.

## Operation
- Pointer ptr (ID_W bits) marks the highest-priority requester. Reset value is 0.
- Arbitration:
  - Scan req starting at ptr, wrapping modulo N_REQ. The first set bit i gets gnt[i]=1.
  - gnt = 0 when req = 0, hold = 1 or rst = 1.
- On a clock edge with rst = 0 and hold = 0:
  - Every stage k copies stage k-1 (data, valid, id).
  - Stage 0 loads {din slice i, 1, i} if requester i is granted, otherwise {0, 0, 0}.
  - ptr becomes (i+1) mod N_REQ after a grant to i. ptr is unchanged when nothing is granted.
- On a clock edge with hold = 1 and rst = 0: all stages, ptr and occupancy keep their values.
- Outputs:
  - dout, dout_vld and dout_id are taken from stage DEPTH-1, so they are registered.
  - occupancy is kept as a registered counter, updated as +1 if stage 0 loads valid and -1 if a valid sample shifts out of the last stage. It must equal the popcount of the stage valid flags.
- Reset: all stage data, valid and id go to 0, ptr goes to 0, occupancy goes to 0. Therefore dout = 0, dout_vld = 0 and dout_id = 0 in the cycle after the reset edge.
- Reset mid-operation flushes every in-flight sample. No flushed sample ever appears on dout.
- Requesters must hold req and din stable until they see gnt. Dropping req without a grant is legal and is simply not served.

## Timing
- Latency:
  - A grant in cycle t means stage 0 is loaded at the end of cycle t.
  - dout_vld = 1 in cycle t+DEPTH when no hold occurs in between.
  - Each hold cycle adds one cycle of latency.
- Throughput: one sample per non-hold cycle, with no bubbles when requests are continuous.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,…,N_REQ-1. Any requesting port waits at most N_REQ-1 non-hold cycles for a grant.
- rst and hold asserted together: rst wins.
- A grant and the pipeline's final shift-out in the same edge: occupancy is unchanged (+1 and -1 cancel).
- ptr wraps from N_REQ-1 to 0. For non-power-of-two N_REQ, ptr never takes values ≥ N_REQ.

## Structure
- Shared package pipe_arb_pkg holds:
  - the ID width function clog2;
  - default constants DEF_N_REQ = 4, DEF_DEPTH = 3, DEF_W = 1.
- Sub-module rr_arbiter contains ptr, the wrap-around priority scan and the gnt/index outputs. Its parameter is N_REQ and its inputs are clk, rst, req, en.
- The top level holds the stage register array, the occupancy counter and the output wiring.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with req = 4'b1111.
  - Required: gnt = 0 throughout, dout_vld = 0 and occupancy = 0 after release.
  - Required: the first grant after release is gnt = 4'b0001.
- Single requester:
  - Stimulus: req = 4'b0100 for one cycle with din slice 2 = 1, defaults (DEPTH = 3).
  - Required: dout = 1, dout_vld = 1, dout_id = 2 exactly 3 cycles later.
  - Required: occupancy reads 1 for 3 cycles, then 0.
- Round robin:
  - Stimulus: req = 4'b1111 held for 8 cycles.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001, and so on.
  - Required: dout_id sequence 0,1,2,3,0,… starting 3 cycles later; occupancy saturates at 3.
- Hold:
  - Stimulus: a single grant to requester 1, then hold = 1 for 2 cycles beginning the cycle after the grant.
  - Required: dout_vld arrives at t+5 instead of t+3, and gnt = 0 during hold.
  - Required: ptr and occupancy are unchanged across the hold.
- Reset mid-flight:
  - Stimulus: three consecutive grants, then rst for 1 cycle.
  - Required: dout_vld stays 0 for the next 3 cycles and occupancy = 0.
- Skip idle ports:
  - Stimulus: ptr = 1 with req = 4'b1001.
  - Required: grant goes to requester 3, then ptr = 0, then the next grant goes to requester 0.
